// File: rtl/bp_resolve_queue.sv
// In-order queue that pairs fetch-time branch predictions with execute-time outcomes
// and drives the predictor update port; BPQ_STATS_EN adds saturating branch/mispredict counters.
module bp_resolve_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_valid,
    input  logic             push_predict,
    output logic             push_ready,
    input  logic             resolve_valid,
    input  logic             resolve_taken,
    input  logic             flush,
    output logic             renew_valid,
    output logic             last_predict,
    output logic             renew_result,
    output logic             mispredict,
    output logic [PTR_W:0]   count,
    output logic             underflow_err
`ifdef BPQ_STATS_EN
    ,
    output logic [15:0]      stat_branches,
    output logic [15:0]      stat_mispredicts
`endif
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             renew_valid_q, renew_valid_d;
    logic             last_predict_q, last_predict_d;
    logic             renew_result_q, renew_result_d;
    logic             mispredict_q, mispredict_d;
    logic             underflow_q, underflow_d;
    logic             push_acc, pop_acc, pop_bit;

    assign push_ready = (count_q != FULL_CNT);
    assign push_acc   = push_valid && push_ready && !flush;
    assign pop_acc    = resolve_valid && (count_q != '0) && !flush;
    assign pop_bit    = mem_q[rp_q];

    always_comb begin
        mem_d          = mem_q;
        wp_d           = wp_q;
        rp_d           = rp_q;
        count_d        = count_q;
        renew_valid_d  = pop_acc;
        last_predict_d = last_predict_q;
        renew_result_d = renew_result_q;
        mispredict_d   = 1'b0;
        underflow_d    = underflow_q;

        if (resolve_valid && (count_q == '0) && !flush) begin
            underflow_d = 1'b1;
        end

        if (push_acc) begin
            mem_d[wp_q] = push_predict;
            wp_d        = wp_q + PTR_W'(1);
        end

        // Update payload only moves on an accepted resolve; it holds otherwise.
        if (pop_acc) begin
            rp_d           = rp_q + PTR_W'(1);
            last_predict_d = pop_bit;
            renew_result_d = resolve_taken;
            mispredict_d   = (pop_bit != resolve_taken);
        end

        case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase

        // Flush wins over everything except the sticky underflow flag.
        if (flush) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q          <= '0;
            wp_q           <= '0;
            rp_q           <= '0;
            count_q        <= '0;
            renew_valid_q  <= 1'b0;
            last_predict_q <= 1'b0;
            renew_result_q <= 1'b0;
            mispredict_q   <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            mem_q          <= mem_d;
            wp_q           <= wp_d;
            rp_q           <= rp_d;
            count_q        <= count_d;
            renew_valid_q  <= renew_valid_d;
            last_predict_q <= last_predict_d;
            renew_result_q <= renew_result_d;
            mispredict_q   <= mispredict_d;
            underflow_q    <= underflow_d;
        end
    end

    assign renew_valid   = renew_valid_q;
    assign last_predict  = last_predict_q;
    assign renew_result  = renew_result_q;
    assign mispredict    = mispredict_q;
    assign count         = count_q;
    assign underflow_err = underflow_q;

`ifdef BPQ_STATS_EN
    logic [15:0] stat_branches_q, stat_branches_d;
    logic [15:0] stat_mispredicts_q, stat_mispredicts_d;

    always_comb begin
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (renew_valid_q && (stat_branches_q != 16'hFFFF)) begin
            stat_branches_d = stat_branches_q + 16'd1;
        end
        if (mispredict_q && (stat_mispredicts_q != 16'hFFFF)) begin
            stat_mispredicts_d = stat_mispredicts_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches_q    <= 16'd0;
            stat_mispredicts_q <= 16'd0;
        end else begin
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Directed bench for bp_resolve_queue: a vector table for the basic flows plus
// hand-written sequences for full, simultaneous push/pop and pointer wrap.
module tb_bp_resolve_queue;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    // Each vector: inputs applied for one cycle, outputs expected just after that edge.
    typedef struct {
        logic [4:0] in_bits;   // {push_valid, push_predict, resolve_valid, resolve_taken, flush}
        logic [3:0] out_bits;  // {renew_valid, last_predict, renew_result, mispredict}
        logic [3:0] cnt;
        logic       rdy;
        logic       uf;
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic             push_valid, push_predict, resolve_valid, resolve_taken, flush;
    logic             push_ready, renew_valid, last_predict, renew_result, mispredict;
    logic [PTR_W:0]   count;
    logic             underflow_err;
`ifdef BPQ_STATS_EN
    logic [15:0]      stat_branches, stat_mispredicts;
`endif

    int n_pass = 0;
    int n_total = 0;
    int exp_branches = 0;
    int exp_mis = 0;
    logic [0:0] exp_q[$];
    vec_t vecs[19];

    bp_resolve_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .push_valid    (push_valid),
        .push_predict  (push_predict),
        .push_ready    (push_ready),
        .resolve_valid (resolve_valid),
        .resolve_taken (resolve_taken),
        .flush         (flush),
        .renew_valid   (renew_valid),
        .last_predict  (last_predict),
        .renew_result  (renew_result),
        .mispredict    (mispredict),
        .count         (count),
        .underflow_err (underflow_err)
`ifdef BPQ_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic drive(input logic pv, input logic pp, input logic rv, input logic rt, input logic fl);
        push_valid    = pv;
        push_predict  = pp;
        resolve_valid = rv;
        resolve_taken = rt;
        flush         = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_renew(input string name, input logic e_rv, input logic e_lp,
                             input logic e_rr, input logic e_mp);
        chk({name, ".renew_valid"}, 16'(renew_valid), 16'(e_rv));
        if (e_rv) begin
            chk({name, ".last_predict"}, 16'(last_predict), 16'(e_lp));
            chk({name, ".renew_result"}, 16'(renew_result), 16'(e_rr));
        end
        chk({name, ".mispredict"}, 16'(mispredict), 16'(e_mp));
        if (e_rv) exp_branches++;
        if (e_mp) exp_mis++;
    endtask

    initial begin
        int idx;
        logic p, t, e;
        logic [7:0] pat;

        vecs[0]  = '{5'b11000, 4'b0000, 4'd1, 1'b1, 1'b0};
        vecs[1]  = '{5'b10000, 4'b0000, 4'd2, 1'b1, 1'b0};
        vecs[2]  = '{5'b11000, 4'b0000, 4'd3, 1'b1, 1'b0};
        vecs[3]  = '{5'b00110, 4'b1110, 4'd2, 1'b1, 1'b0};
        vecs[4]  = '{5'b00110, 4'b1011, 4'd1, 1'b1, 1'b0};
        vecs[5]  = '{5'b00110, 4'b1110, 4'd0, 1'b1, 1'b0};
        vecs[6]  = '{5'b00000, 4'b0110, 4'd0, 1'b1, 1'b0};
        vecs[7]  = '{5'b00100, 4'b0110, 4'd0, 1'b1, 1'b1};  // underflow
        vecs[8]  = '{5'b10110, 4'b0110, 4'd1, 1'b1, 1'b1};  // empty push+resolve
        vecs[9]  = '{5'b00110, 4'b1011, 4'd0, 1'b1, 1'b1};
        vecs[10] = '{5'b11000, 4'b0010, 4'd1, 1'b1, 1'b1};
        vecs[11] = '{5'b11000, 4'b0010, 4'd2, 1'b1, 1'b1};
        vecs[12] = '{5'b10000, 4'b0010, 4'd3, 1'b1, 1'b1};
        vecs[13] = '{5'b10000, 4'b0010, 4'd4, 1'b1, 1'b1};
        vecs[14] = '{5'b11000, 4'b0010, 4'd5, 1'b1, 1'b1};
        vecs[15] = '{5'b00111, 4'b0010, 4'd0, 1'b1, 1'b1};  // flush + resolve
        vecs[16] = '{5'b10001, 4'b0010, 4'd0, 1'b1, 1'b1};  // flush + push
        vecs[17] = '{5'b10000, 4'b0010, 4'd1, 1'b1, 1'b1};
        vecs[18] = '{5'b00100, 4'b1000, 4'd0, 1'b1, 1'b1};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset.count", 16'(count), 16'd0);
        chk("reset.push_ready", 16'(push_ready), 16'd1);
        chk("reset.underflow_err", 16'(underflow_err), 16'd0);
        chk_renew("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.last_predict", 16'(last_predict), 16'd0);
        chk("reset.renew_result", 16'(renew_result), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].in_bits[4], vecs[i].in_bits[3], vecs[i].in_bits[2],
                  vecs[i].in_bits[1], vecs[i].in_bits[0]);
            tick();
            chk($sformatf("vec%0d.renew_valid", i), 16'(renew_valid), 16'(vecs[i].out_bits[3]));
            chk($sformatf("vec%0d.last_predict", i), 16'(last_predict), 16'(vecs[i].out_bits[2]));
            chk($sformatf("vec%0d.renew_result", i), 16'(renew_result), 16'(vecs[i].out_bits[1]));
            chk($sformatf("vec%0d.mispredict", i), 16'(mispredict), 16'(vecs[i].out_bits[0]));
            chk($sformatf("vec%0d.count", i), 16'(count), 16'(vecs[i].cnt));
            chk($sformatf("vec%0d.push_ready", i), 16'(push_ready), 16'(vecs[i].rdy));
            chk($sformatf("vec%0d.underflow_err", i), 16'(underflow_err), 16'(vecs[i].uf));
            if (vecs[i].out_bits[3]) exp_branches++;
            if (vecs[i].out_bits[0]) exp_mis++;
        end

        // Fill to full, attempt a 9th push
        pat = 8'b1011_0010;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, pat[i], 1'b0, 1'b0, 1'b0);
            tick();
            chk($sformatf("fill%0d.count", i), 16'(count), 16'(i + 1));
        end
        chk("full.push_ready", 16'(push_ready), 16'd0);
        drive(1'b1, ~pat[0], 1'b0, 1'b0, 1'b0);
        tick();
        chk("push_when_full.count", 16'(count), 16'd8);
        chk("push_when_full.push_ready", 16'(push_ready), 16'd0);

        // Full: push and resolve together, only the pop happens
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        chk_renew("full_pushpop", 1'b1, pat[0], 1'b1, pat[0] != 1'b1);
        chk("full_pushpop.count", 16'(count), 16'd7);
        chk("full_pushpop.push_ready", 16'(push_ready), 16'd1);
        for (int i = 1; i < DEPTH; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            tick();
            chk_renew($sformatf("drain%0d", i), 1'b1, pat[i], 1'b0, pat[i]);
            chk($sformatf("drain%0d.count", i), 16'(count), 16'(DEPTH - 1 - i));
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_renew("drain_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Wrap-around: 7 rounds of 3 pushes then 3 resolves
        idx = 0;
        for (int r = 0; r < 7; r++) begin
            for (int k = 0; k < 3; k++) begin
                p = idx[0] ^ idx[2];
                drive(1'b1, p, 1'b0, 1'b0, 1'b0);
                exp_q.push_back(p);
                tick();
                chk($sformatf("wrap_push%0d.count", idx), 16'(count), 16'(k + 1));
                idx++;
            end
            for (int k = 0; k < 3; k++) begin
                t = idx[1];
                e = exp_q.pop_front();
                drive(1'b0, 1'b0, 1'b1, t, 1'b0);
                tick();
                chk_renew($sformatf("wrap_pop%0d", idx), 1'b1, e, t, e != t);
                chk($sformatf("wrap_pop%0d.count", idx), 16'(count), 16'(2 - k));
                idx++;
            end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("final.count", 16'(count), 16'd0);
        chk("final.underflow_err", 16'(underflow_err), 16'd1);

`ifdef BPQ_STATS_EN
        chk("stat_branches", stat_branches, 16'(exp_branches));
        chk("stat_mispredicts", stat_mispredicts, 16'(exp_mis));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bp_resolve_queue.md
Name: bp_resolve_queue

Overview:
- In-order tracking queue between fetch-stage branch prediction and execute-stage branch resolution.
- Records each issued prediction bit at fetch.
- Pairs each prediction with the actual outcome from execute, oldest first.
- Drives the global predictor's update interface (renew_valid / last_predict / renew_result), one cycle after resolution.
- Also flags mispredicts to the pipeline flush logic.

Parameters:
- DEPTH, 8, number of in-flight branch entries; power of two, >= 2.
- PTR_W, 3, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous reset, active low
- push_valid  input  1  fetch issued a predicted branch this cycle
- push_predict  input  1  predicted direction (1 = taken)
- push_ready  output  1  queue can accept a push; high when not full
- resolve_valid  input  1  execute resolved the oldest outstanding branch
- resolve_taken  input  1  actual direction (1 = taken)
- flush  input  1  pipeline flush; discard all outstanding entries
- renew_valid  output  1  update strobe to predictor
- last_predict  output  1  prediction paired with this update
- renew_result  output  1  actual outcome for this update
- mispredict  output  1  last_predict != renew_result, qualified by renew_valid
- count  output  PTR_W+1  occupancy, 0..DEPTH
- underflow_err  output  1  sticky: resolve arrived while queue empty

Behaviour:
- Reset (async, rst_n low): pointers 0, count 0.
  - renew_valid, last_predict, renew_result, mispredict and underflow_err are 0.
  - push_ready is 1.
  - Entry storage contents don't care.
- Storage: circular buffer of DEPTH 1-bit entries, write pointer wp, read pointer rp.
  - Pointers are PTR_W bits and wrap naturally from DEPTH-1 to 0.
  - count is a separate (PTR_W+1)-bit register.
- push_ready = (count != DEPTH), combinational from registered count.
  - A push with push_ready low is ignored; no state change.
- Push accepted (push_valid && push_ready && !flush): mem[wp] <= push_predict, wp <= wp+1.
- Resolve accepted (resolve_valid && count != 0 && !flush): pop mem[rp], rp <= rp+1.
  - Next cycle: renew_valid=1, last_predict=mem[rp], renew_result=resolve_taken, mispredict=(mem[rp]!=resolve_taken).
  - Latency is exactly 1 cycle. Outputs are registered.
  - renew_valid, and therefore mispredict, is 1 only in the cycle following an accepted resolve, 0 otherwise.
  - last_predict and renew_result hold their values when renew_valid is 0.
- Simultaneous push and resolve (both accepted): count unchanged, both pointers advance.
  - When full: push_ready is already low, so only the pop occurs and count becomes DEPTH-1.
  - When empty: no bypass. The resolve is an underflow, and the push is stored normally (count becomes 1).
- Underflow (resolve_valid && count==0 && !flush): underflow_err <= 1, sticky until reset.
  - No renew is generated and pointers are unchanged.
- flush: the next cycle has wp=rp=0 and count=0.
  - Any same-cycle push or resolve is dropped.
  - renew_valid next cycle is 0, even if resolve_valid was high.
  - flush has priority over every other event. underflow_err is not cleared.
- count invariant: count == (wp - rp) mod DEPTH, except when full (wp == rp and count == DEPTH).

Optional Feature:
- Macro BPQ_STATS_EN.
- Defined: adds outputs stat_branches[15:0] (incremented on each renew_valid) and stat_mispredicts[15:0] (incremented on each mispredict).
  - Both saturate at 16'hFFFF, reset to 0 on rst_n, and are unaffected by flush.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Push predictions 1,0,1 on consecutive cycles, then resolve 1,1,1. Expected: renew_valid on 3 consecutive cycles, each 1 cycle after its resolve, with last_predict 1,0,1, renew_result 1,1,1, mispredict 0,1,0, and count returning 0.
- Push 8 entries (DEPTH=8), then attempt a 9th push. Expected: count=8 and push_ready=0, the 9th entry is not stored, and 8 resolves return exactly the first 8 predictions in order.
- With count=8, assert push and resolve in the same cycle. Expected: the pop happens, the push is dropped, count=7, and push_ready=1 next cycle.
- Resolve while empty. Expected: underflow_err=1 and stays 1, renew_valid=0, count=0. A later push then resolve operates normally.
- With 5 entries queued, assert flush together with resolve_valid. Expected: count=0 and renew_valid=0 next cycle, and a fresh push then resolve returns the fresh prediction.
- Wrap-around: run 20 push/resolve pairs with count oscillating 0..3. Expected: every renew matches its own push, which checks the pointer wrap.
- With BPQ_STATS_EN: 4 resolves with 2 mispredicts. Expected: stat_branches=4 and stat_mispredicts=2.
